// File: rtl/if_id_queue_pkg.sv
// ============================================================================
// Module      : if_id_queue_pkg
// Description : Shared widths, NOP encoding and default depth for the
//               fetch-to-decode instruction queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef WORD
`define WORD 64
`endif
`ifndef INST_SIZE
`define INST_SIZE 32
`endif
`ifndef INST_NOP
`define INST_NOP 32'hD503201F
`endif
`ifndef IFQ_DEPTH
`define IFQ_DEPTH 4
`endif

package if_id_queue_pkg;

    localparam int          c_WORD      = `WORD;
    localparam int          c_INST_SIZE = `INST_SIZE;
    localparam logic [31:0] c_INST_NOP  = `INST_NOP;
    localparam int          c_IFQ_DEPTH = `IFQ_DEPTH;

    // Pointer width for a power-of-two depth; never collapses to zero bits.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ifq_ptr.sv
// ============================================================================
// Module      : ifq_ptr
// Description : Wrap-around queue pointer with synchronous clear and
//               increment enable.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifq_ptr #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_ptr
);

    logic [WIDTH-1:0] r_ptr;

    // Natural binary overflow provides the modulo-DEPTH wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_clr) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= r_ptr + WIDTH'(1);
        end
    end

    assign o_ptr = r_ptr;

endmodule

`default_nettype wire

// File: rtl/if_id_queue.sv
// ============================================================================
// Module      : if_id_queue
// Description : IF/ID decoupling queue carrying {pc, pc_incr, inst} from
//               fetch to decode with valid/ready handshake and flush.
//               Optional macro IFQ_BYPASS_EN adds an empty-queue bypass.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int DEPTH     = c_IFQ_DEPTH,
    parameter int WORD      = c_WORD,
    parameter int INST_SIZE = c_INST_SIZE
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WORD-1:0]        in_pc,
    input  logic [WORD-1:0]        in_pc_incr,
    input  logic [INST_SIZE-1:0]   in_inst,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORD-1:0]        out_pc,
    output logic [WORD-1:0]        out_pc_incr,
    output logic [INST_SIZE-1:0]   out_inst,
    output logic [$clog2(DEPTH):0] count
);

    localparam int c_PTR_W = ptr_width(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("if_id_queue: DEPTH must be a power of two >= 2");
        end
    endgenerate

    logic [WORD-1:0]      r_pc_mem   [DEPTH];
    logic [WORD-1:0]      r_incr_mem [DEPTH];
    logic [INST_SIZE-1:0] r_inst_mem [DEPTH];
    logic [c_CNT_W-1:0]   r_count;
    logic [c_PTR_W-1:0]   w_wr_ptr;
    logic [c_PTR_W-1:0]   w_rd_ptr;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;

    assign w_empty  = (r_count == '0);
    assign in_ready = (r_count != c_CNT_W'(DEPTH));
    assign w_pop    = !w_empty && out_ready && !flush;

`ifdef IFQ_BYPASS_EN
    logic w_bypass;

    // An empty queue forwards fetch straight to decode; the entry is only
    // stored when decode cannot take it this cycle.
    assign w_bypass  = w_empty && in_valid && !flush;
    assign w_push    = in_valid && in_ready && !flush && !(w_bypass && out_ready);
    assign out_valid = !w_empty || w_bypass;

    always_comb begin
        out_pc      = '0;
        out_pc_incr = '0;
        out_inst    = INST_SIZE'(c_INST_NOP);
        if (w_bypass) begin
            out_pc      = in_pc;
            out_pc_incr = in_pc_incr;
            out_inst    = in_inst;
        end else if (!w_empty) begin
            out_pc      = r_pc_mem[w_rd_ptr];
            out_pc_incr = r_incr_mem[w_rd_ptr];
            out_inst    = r_inst_mem[w_rd_ptr];
        end
    end
`else
    assign w_push    = in_valid && in_ready && !flush;
    assign out_valid = !w_empty;

    always_comb begin
        out_pc      = '0;
        out_pc_incr = '0;
        out_inst    = INST_SIZE'(c_INST_NOP);
        if (!w_empty) begin
            out_pc      = r_pc_mem[w_rd_ptr];
            out_pc_incr = r_incr_mem[w_rd_ptr];
            out_inst    = r_inst_mem[w_rd_ptr];
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (flush) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked entirely by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[w_wr_ptr]   <= in_pc;
            r_incr_mem[w_wr_ptr] <= in_pc_incr;
            r_inst_mem[w_wr_ptr] <= in_inst;
        end
    end

    ifq_ptr #(.WIDTH(c_PTR_W)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (flush),
        .i_inc (w_push),
        .o_ptr (w_wr_ptr)
    );

    ifq_ptr #(.WIDTH(c_PTR_W)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (flush),
        .i_inc (w_pop),
        .o_ptr (w_rd_ptr)
    );

    assign count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_if_id_queue.sv
// ============================================================================
// Module      : tb_if_id_queue
// Description : Scoreboard bench for if_id_queue (DEPTH = 4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_id_queue;

    localparam logic [31:0] c_NOP = 32'hD503201F;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_pc;
    logic [63:0] in_pc_incr;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [63:0] out_pc_incr;
    logic [31:0] out_inst;
    logic [2:0]  count;

    int n_checks = 0;
    int n_err    = 0;
    logic [159:0] exp_q[$];

    if_id_queue dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pc       (in_pc),
        .in_pc_incr  (in_pc_incr),
        .in_inst     (in_inst),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_pc_incr (out_pc_incr),
        .out_inst    (out_inst),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_push(input logic [63:0] pc, input logic [31:0] inst, input bit expect_it);
        in_valid   = 1'b1;
        in_pc      = pc;
        in_pc_incr = pc + 64'd4;
        in_inst    = inst;
        if (expect_it) exp_q.push_back({pc, pc + 64'd4, inst});
    endtask

    task automatic idle_in();
        in_valid   = 1'b0;
        in_pc      = '0;
        in_pc_incr = '0;
        in_inst    = '0;
    endtask

    // Monitor: every accepted head entry must match the oldest expectation.
    initial begin
        logic [159:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && !flush && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_pop: got pc %h, nothing expected", out_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("pop_order", {out_pc, out_pc_incr, out_inst}, e);
                end
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        flush      = 1'b0;
        out_ready  = 1'b0;
        in_valid   = 1'b0;
        in_pc      = {$urandom, $urandom};
        in_pc_incr = {$urandom, $urandom};
        in_inst    = $urandom;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_inst",  out_inst,  c_NOP);
        chk("rst_out_pc",    out_pc,    0);
        chk("rst_count",     count,     0);
        chk("rst_in_ready",  in_ready,  1);
        rst_n = 1'b1;
        tick();
        idle_in();
        tick();
        @(negedge clk);
        chk("idle_out_valid", out_valid, 0);
        chk("idle_out_inst",  out_inst,  c_NOP);
        chk("idle_count",     count,     0);

        // Fill to full, reject a 5th push, then drain in order
        tick();
        for (int i = 0; i < 4; i++) begin
            drive_push(64'(4 * i), 32'h8B00_0000 + 32'(i), 1'b1);
            tick();
        end
        drive_push(64'h10, 32'h8B00_0004, 1'b0);
        @(negedge clk);
        chk("full_count",    count,    4);
        chk("full_in_ready", in_ready, 0);
        tick();
        idle_in();
        @(negedge clk);
        chk("full_no_5th", count, 4);
        tick();
        out_ready = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        chk("drain_count",    count,     0);
        chk("drain_valid",    out_valid, 0);
        chk("drain_out_inst", out_inst,  c_NOP);
        chk("drain_out_pc",   out_pc,    0);

        // Simultaneous push and pop at count = 2 across pointer wraps
        tick();
        out_ready = 1'b0;
        drive_push(64'h1000, 32'hA000_0000, 1'b1);
        tick();
        drive_push(64'h1004, 32'hA000_0001, 1'b1);
        tick();
        for (int k = 0; k < 10; k++) begin
            drive_push(64'h1008 + 64'(4 * k), 32'hA000_0002 + 32'(k), 1'b1);
            out_ready = 1'b1;
            tick();
        end
        idle_in();
        out_ready = 1'b0;
        @(negedge clk);
        chk("pp_count",    count,    2);
        chk("pp_in_ready", in_ready, 1);

        // Flush at count = 3 with a same-cycle push
        tick();
        drive_push(64'h2000, 32'hB000_0000, 1'b1);
        tick();
        flush = 1'b1;
        drive_push(64'h40, 32'hB000_0040, 1'b0);
        exp_q.delete();
        @(negedge clk);
        chk("flush_in_ready_pre", in_ready, 1);
        tick();
        flush = 1'b0;
        idle_in();
        @(negedge clk);
        chk("flush_count", count,     0);
        chk("flush_valid", out_valid, 0);
        tick();
        drive_push(64'h100, 32'hB000_0100, 1'b1);
        out_ready = 1'b1;
        tick();
        idle_in();
        tick();
        @(negedge clk);
        chk("post_flush_count", count, 0);

        // Full with a pop the same cycle: push accepted only one cycle later
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_push(64'h3000 + 64'(4 * i), 32'hC000_0000 + 32'(i), 1'b1);
            tick();
        end
        drive_push(64'h20, 32'hC000_0020, 1'b1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("fullpop_in_ready", in_ready, 0);
        tick();
        @(negedge clk);
        chk("fullpop_count_next", count,    3);
        chk("fullpop_ready_next", in_ready, 1);
        tick();
        idle_in();
        @(negedge clk);
        chk("fullpop_count_hold", count, 3);
        repeat (4) tick();
        @(negedge clk);
        chk("fullpop_drained", count, 0);

        // Latency from an empty queue
        tick();
        drive_push(64'h200, 32'hD000_0200, 1'b1);
        out_ready = 1'b1;
        @(negedge clk);
`ifdef IFQ_BYPASS_EN
        chk("lat_valid_same", out_valid, 1);
        chk("lat_pc_same",    out_pc,    64'h200);
        chk("lat_count_same", count,     0);
`else
        chk("lat_valid_same", out_valid, 0);
        chk("lat_count_same", count,     0);
`endif
        tick();
        idle_in();
        @(negedge clk);
`ifdef IFQ_BYPASS_EN
        chk("lat_valid_next", out_valid, 0);
        chk("lat_count_next", count,     0);
`else
        chk("lat_valid_next", out_valid, 1);
        chk("lat_pc_next",    out_pc,    64'h200);
        chk("lat_count_next", count,     1);
`endif
        tick();
        @(negedge clk);
        chk("lat_final_count", count, 0);

        // Asynchronous reset mid-operation
        tick();
        out_ready = 1'b0;
        drive_push(64'h500, 32'hE000_0000, 1'b1);
        tick();
        drive_push(64'h504, 32'hE000_0001, 1'b1);
        tick();
        idle_in();
        #2 rst_n = 1'b0;
        #1;
        chk("areset_count", count,     0);
        chk("areset_valid", out_valid, 0);
        chk("areset_inst",  out_inst,  c_NOP);
        exp_q.delete();
        #2 rst_n = 1'b1;
        tick();
        @(negedge clk);
        chk("areset_after", count, 0);

        chk("scoreboard_empty", 160'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
